// File: rtl/add_arb_pkg.sv
// Shared widths, FSM encoding and response-tag helpers for the add_arb slice.
package add_arb_pkg;

    localparam int NREQ   = 4;
    localparam int REQ_W  = 2;
    localparam int HT_W   = 5;
    localparam int TAG_W  = REQ_W + HT_W;
    localparam int DATA_W = 64;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [TAG_W-1:0] tag_pack(input logic [REQ_W-1:0] req_id,
                                                   input logic [HT_W-1:0]  ht_id);
        return {req_id, ht_id};
    endfunction

    function automatic logic [REQ_W-1:0] tag_req(input logic [TAG_W-1:0] tag);
        return tag[TAG_W-1:HT_W];
    endfunction

    function automatic logic [HT_W-1:0] tag_ht(input logic [TAG_W-1:0] tag);
        return tag[HT_W-1:0];
    endfunction

endpackage

// File: rtl/add_5stage.sv
// Five-cycle modulo-2^DATA_W adder with a pass-through tag; registers carry no reset.
module add_5stage #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 7
) (
    input  logic              ck,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [TAG_W-1:0]  i_htId,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_res,
    output logic [TAG_W-1:0]  o_htId
);

    localparam int H = DATA_W / 2;

    logic              vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
    logic [TAG_W-1:0]  tag_p0, tag_p1, tag_p2, tag_p3, tag_p4;
    logic [DATA_W-1:0] a_p0, b_p0;
    logic [H:0]        lo_p1;
    logic [H-1:0]      a_hi_p1, b_hi_p1;
    logic [DATA_W-1:0] sum_p2, sum_p3, sum_p4;

    always_ff @(posedge ck) begin
        // p0: operand capture
        vld_p0  <= i_vld;
        tag_p0  <= i_htId;
        a_p0    <= i_a;
        b_p0    <= i_b;
        // p1: low half with carry out
        vld_p1  <= vld_p0;
        tag_p1  <= tag_p0;
        lo_p1   <= {1'b0, a_p0[H-1:0]} + {1'b0, b_p0[H-1:0]};
        a_hi_p1 <= a_p0[DATA_W-1:H];
        b_hi_p1 <= b_p0[DATA_W-1:H];
        // p2: high half absorbs the carry, overflow wraps
        vld_p2  <= vld_p1;
        tag_p2  <= tag_p1;
        sum_p2  <= {a_hi_p1 + b_hi_p1 + H'(lo_p1[H]), lo_p1[H-1:0]};
        // p3/p4: retiming stages
        vld_p3  <= vld_p2;
        tag_p3  <= tag_p2;
        sum_p3  <= sum_p2;
        vld_p4  <= vld_p3;
        tag_p4  <= tag_p3;
        sum_p4  <= sum_p3;
    end

    assign o_vld  = vld_p4;
    assign o_res  = sum_p4;
    assign o_htId = tag_p4;

endmodule

// File: rtl/add_arb_fifo.sv
// Synchronous response FIFO; only pointers and count are reset, storage is not.
module add_arb_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 71,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             ck,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = i_pop && (count != '0);

    always_ff @(posedge ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({i_push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (i_push) mem[wr_ptr] <= i_data;
    end

    // Head is forced to zero while empty so outputs are clean out of reset.
    assign o_vld   = (count != '0);
    assign o_data  = o_vld ? mem[rd_ptr] : '0;
    assign o_count = count;

`ifndef SYNTHESIS
    no_overflow: assert property (@(posedge ck) disable iff (!i_rst_n)
        !(i_push && !pop_ok && (count == CNT_W'(DEPTH))));
`endif

endmodule

// File: rtl/add_arb.sv
// Round-robin, credit-limited sharing of one add_5stage among four requesters.
module add_arb
    import add_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PIPE_LAT   = 5
) (
    input  logic                   ck,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req_vld,
    input  logic [NREQ*DATA_W-1:0] i_req_a,
    input  logic [NREQ*DATA_W-1:0] i_req_b,
    input  logic [NREQ*HT_W-1:0]   i_req_htId,
    output logic [NREQ-1:0]        o_req_rdy,
    output logic                   o_rsp_vld,
    output logic [DATA_W-1:0]      o_rsp_res,
    output logic [REQ_W-1:0]       o_rsp_reqId,
    output logic [HT_W-1:0]        o_rsp_htId,
    input  logic                   i_rsp_rdy
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = DATA_W + TAG_W;

    state_t            state_q, state_d;
    logic [2:0]        flush_cnt_q;
    logic [REQ_W-1:0]  last_grant_q, gnt_idx;
    logic              gnt_found, grant_en, xfer, ret_vld;
    logic [CNT_W-1:0]  inflight_q, fifo_count;
    logic [CNT_W:0]    used;
    logic              pipe_o_vld;
    logic [DATA_W-1:0] pipe_i_a, pipe_i_b, pipe_o_res;
    logic [TAG_W-1:0]  pipe_i_tag, pipe_o_tag;
    logic [FIFO_W-1:0] fifo_head;

    // The adder has no reset, so its contents are drained for PIPE_LAT cycles first.
    always_ff @(posedge ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FLUSH) flush_cnt_q <= flush_cnt_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH: if (flush_cnt_q == 3'(PIPE_LAT - 1)) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Every issued op owns a FIFO slot until it is popped, so overflow cannot occur.
    assign used     = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign grant_en = (state_q == ST_RUN) && (used < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && i_req_vld[last_grant_q + REQ_W'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = last_grant_q + REQ_W'(k);
            end
        end
    end

    assign xfer       = grant_en && gnt_found;
    assign o_req_rdy  = xfer ? (NREQ'(1) << gnt_idx) : '0;
    assign pipe_i_a   = i_req_a[gnt_idx*DATA_W +: DATA_W];
    assign pipe_i_b   = i_req_b[gnt_idx*DATA_W +: DATA_W];
    assign pipe_i_tag = tag_pack(gnt_idx, i_req_htId[gnt_idx*HT_W +: HT_W]);
    assign ret_vld    = pipe_o_vld && (state_q == ST_RUN);

    always_ff @(posedge ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_q <= REQ_W'(NREQ - 1);
            inflight_q   <= '0;
        end else begin
            if (xfer) last_grant_q <= gnt_idx;
            case ({xfer, ret_vld})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: ;
            endcase
        end
    end

    add_5stage #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_pipe (
        .ck     (ck),
        .i_vld  (xfer),
        .i_a    (pipe_i_a),
        .i_b    (pipe_i_b),
        .i_htId (pipe_i_tag),
        .o_vld  (pipe_o_vld),
        .o_res  (pipe_o_res),
        .o_htId (pipe_o_tag)
    );

    add_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .ck      (ck),
        .i_rst_n (i_rst_n),
        .i_push  (ret_vld),
        .i_data  ({pipe_o_res, pipe_o_tag}),
        .i_pop   (i_rsp_rdy),
        .o_vld   (o_rsp_vld),
        .o_data  (fifo_head),
        .o_count (fifo_count)
    );

    assign o_rsp_res   = fifo_head[FIFO_W-1:TAG_W];
    assign o_rsp_reqId = tag_req(fifo_head[TAG_W-1:0]);
    assign o_rsp_htId  = tag_ht(fifo_head[TAG_W-1:0]);

endmodule

// File: tb/tb_add_arb.sv
// Randomised bench for add_arb with a queue-based reference model and literal anchors.
module tb_add_arb;

    localparam int FIFO_DEPTH = 8;
    localparam int PIPE_LAT   = 5;

    logic         ck;
    logic         rst_n;
    logic [3:0]   req_vld;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [19:0]  req_ht;
    logic [3:0]   req_rdy;
    logic         rsp_vld;
    logic [63:0]  rsp_res;
    logic [1:0]   rsp_reqId;
    logic [4:0]   rsp_htId;
    logic         rsp_rdy;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  rid;
        logic [4:0]  ht;
        int          t;
    } exp_t;

    exp_t q[$];
    int   rc;
    int   m_last;

    add_arb #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PIPE_LAT   (PIPE_LAT)
    ) dut (
        .ck          (ck),
        .i_rst_n     (rst_n),
        .i_req_vld   (req_vld),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_htId  (req_ht),
        .o_req_rdy   (req_rdy),
        .o_rsp_vld   (rsp_vld),
        .o_rsp_res   (rsp_res),
        .o_rsp_reqId (rsp_reqId),
        .o_rsp_htId  (rsp_htId),
        .i_rsp_rdy   (rsp_rdy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic rand_ops();
        for (int n = 0; n < 4; n++) begin
            req_a[n*64 +: 64] = {$urandom, $urandom};
            req_b[n*64 +: 64] = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                            : {$urandom, $urandom};
            req_ht[n*5 +: 5]  = 5'($urandom);
        end
    endtask

    task automatic drain();
        req_vld = '0;
        rsp_rdy = 1'b1;
        repeat (20) tick();
    endtask

    // Reference model: responses in issue order, visible 6 cycles after issue,
    // credit = FIFO_DEPTH minus everything issued and not yet consumed.
    always @(negedge ck) begin : model
        int          g;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_rdy", 64'(req_rdy), 64'd0);
            chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
            chk("rst_res", rsp_res, 64'd0);
            chk("rst_reqId", 64'(rsp_reqId), 64'd0);
            chk("rst_htId", 64'(rsp_htId), 64'd0);
            q.delete();
            rc     = 0;
            m_last = 3;
        end else begin
            g = -1;
            if (rc >= PIPE_LAT && q.size() < FIFO_DEPTH)
                for (int k = 1; k <= 4; k++)
                    if (g < 0 && req_vld[(m_last + k) % 4]) g = (m_last + k) % 4;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            chk("grant", 64'(req_rdy), 64'(exp_rdy));
            exp_vld = (q.size() > 0) && (rc >= q[0].t + 6);
            chk("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
            if (exp_vld) begin
                chk("rsp_res", rsp_res, q[0].res);
                chk("rsp_reqId", 64'(rsp_reqId), 64'(q[0].rid));
                chk("rsp_htId", 64'(rsp_htId), 64'(q[0].ht));
                if (rsp_rdy) void'(q.pop_front());
            end
            if (g >= 0) begin
                e.res = req_a[g*64 +: 64] + req_b[g*64 +: 64];
                e.rid = 2'(g);
                e.ht  = req_ht[g*5 +: 5];
                e.t   = rc;
                q.push_back(e);
                m_last = g;
            end
            rc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        int next_a;
        logic xf;

        rst_n   = 1'b0;
        req_vld = '0;
        req_a   = '0;
        req_b   = '0;
        req_ht  = '0;
        rsp_rdy = 1'b1;
        repeat (3) tick();

        // All four requesting from cycle 0: silent FLUSH, then 0,1,2,3,0,...
        rand_ops();
        req_vld = 4'hF;
        rst_n   = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge ck);
            chk("flush_then_rr", 64'(req_rdy), 64'((c < PIPE_LAT) ? 0 : (1 << ((c - PIPE_LAT) % 4))));
            tick();
            rand_ops();
        end
        drain();

        // Wrapping add from requester 2, visible exactly 6 cycles later.
        req_vld           = 4'b0100;
        req_a[128 +: 64]  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[128 +: 64]  = 64'd2;
        req_ht[10 +: 5]   = 5'h13;
        tick();
        req_vld = '0;
        repeat (4) tick();
        @(negedge ck);
        chk("lat_early_vld", 64'(rsp_vld), 64'd0);
        tick();
        @(negedge ck);
        chk("lat_vld", 64'(rsp_vld), 64'd1);
        chk("lat_res", rsp_res, 64'd1);
        chk("lat_reqId", 64'(rsp_reqId), 64'd2);
        chk("lat_htId", 64'(rsp_htId), 64'h13);
        drain();

        // Stalled consumer: credit limits requester 1 to exactly FIFO_DEPTH issues.
        rsp_rdy = 1'b0;
        req_vld = 4'b0010;
        n = 0;
        repeat (20) begin
            @(negedge ck);
            if (req_rdy[1]) n++;
            tick();
            rand_ops();
        end
        chk("credit_fill", 64'(n), 64'd8);
        @(negedge ck);
        chk("credit_stall", 64'(req_rdy), 64'd0);
        tick();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge ck);
            if (req_rdy[1]) n++;
            tick();
        end
        chk("credit_one_pop", 64'(n), 64'd1);
        drain();

        // 32 sequential ops a=i, b=0 under a bursty consumer: order across wrap.
        next_a  = 0;
        got     = 0;
        req_vld = 4'b0001;
        req_a[0 +: 64] = 64'd0;
        req_b[0 +: 64] = 64'd0;
        for (int c = 0; c < 3000 && got < 32; c++) begin
            @(negedge ck);
            if (rsp_vld && rsp_rdy) begin
                chk("wrap_order", rsp_res, 64'(got));
                got++;
            end
            xf = req_rdy[0];
            tick();
            if (xf) next_a++;
            req_vld        = (next_a < 32) ? 4'b0001 : 4'b0000;
            req_a[0 +: 64] = 64'(next_a);
            rsp_rdy        = 1'($urandom_range(0, 1));
        end
        chk("wrap_count", 64'(got), 64'd32);
        drain();

        // Requester 0 granted last; 0 and 3 contend, then an idle gap keeps last_grant.
        rand_ops();
        req_vld = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            @(negedge ck);
            chk("rr_pair", 64'(req_rdy), 64'((c % 2 == 0) ? 8 : 1));
            tick();
        end
        req_vld = '0;
        repeat (3) tick();
        req_vld = 4'b1001;
        @(negedge ck);
        chk("rr_hold", 64'(req_rdy), 64'd8);
        tick();
        drain();

        // Reset with 3 ops in flight and 2 buffered; nothing stale may surface.
        rsp_rdy = 1'b0;
        req_vld = 4'b0010;
        rand_ops();
        repeat (5) tick();
        req_vld = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 64'(req_rdy), 64'd0);
        chk("mid_rst_vld", 64'(rsp_vld), 64'd0);
        chk("mid_rst_res", rsp_res, 64'd0);
        chk("mid_rst_reqId", 64'(rsp_reqId), 64'd0);
        chk("mid_rst_htId", 64'(rsp_htId), 64'd0);
        repeat (2) tick();
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        repeat (15) begin
            @(negedge ck);
            chk("no_stale", 64'(rsp_vld), 64'd0);
            tick();
        end

        // Random traffic against the model.
        repeat (600) begin
            rand_ops();
            req_vld = 4'($urandom);
            rsp_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
